// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request bus between the N requesters and the register-file write-port arbiter.
// Requester i occupies bit i of valid/ready, bits [i*AW +: AW] of addr and bits [i*DW +: DW] of data.
interface regfile_wb_arbiter_if #(
  parameter int N_REQ = 3,
  parameter int DW    = 32,
  parameter int AW    = 5
);
  logic [N_REQ-1:0]    req_valid;
  logic [N_REQ*AW-1:0] req_addr;
  logic [N_REQ*DW-1:0] req_data;
  logic [N_REQ-1:0]    req_ready;

  modport master (output req_valid, req_addr, req_data, input req_ready);
  modport slave  (input req_valid, req_addr, req_data, output req_ready);
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin write-port arbiter for the register file, with a zero-clear sweep after reset or clr_req.
// Optional feature: define REGFILE_ZERO_PROTECT_EN to suppress writes to register 0 from requesters.
module regfile_wb_arbiter #(
  parameter int N_REQ = 3,
  parameter int DW    = 32,
  parameter int AW    = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  regfile_wb_arbiter_if.slave  req,
  input  logic                 wb_hold,
  input  logic                 clr_req,
  output logic                 we3,
  output logic [AW-1:0]        wa3,
  output logic [DW-1:0]        wd3,
  output logic                 init_done,
  output logic [2:0]           grant_idx
);

  typedef enum logic {CLEAR, ARB} state_t;

  localparam logic [AW:0] CLR_LAST = (AW+1)'((1 << AW) - 1);

  state_t        state;
  logic [AW:0]   clr_cnt;
  logic [2:0]    ptr;
  logic          gnt_found;
  logic [2:0]    gnt_idx;
  logic [3:0]    cand;
  logic [2:0]    ptr_nxt;
  logic [AW-1:0] gnt_addr;
  logic [DW-1:0] gnt_data;
  logic          gnt_we;

  // Rotating search from ptr; the first valid requester found wins.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    if (state == ARB && !wb_hold && !clr_req) begin
      for (int unsigned k = 0; k < N_REQ; k++) begin
        cand = {1'b0, ptr} + 4'(k);
        if (cand >= 4'(N_REQ)) cand = cand - 4'(N_REQ);
        if (!gnt_found && |(req.req_valid & (N_REQ'(1) << cand))) begin
          gnt_found = 1'b1;
          gnt_idx   = cand[2:0];
        end
      end
    end
    req.req_ready = gnt_found ? (N_REQ'(1) << gnt_idx) : '0;
    gnt_addr      = AW'(req.req_addr >> (AW * int'(gnt_idx)));
    gnt_data      = DW'(req.req_data >> (DW * int'(gnt_idx)));
    ptr_nxt       = (gnt_idx == 3'(N_REQ - 1)) ? 3'd0 : gnt_idx + 3'd1;
  end

`ifdef REGFILE_ZERO_PROTECT_EN
  // The handshake still completes for addr 0; only the write strobe is dropped.
  assign gnt_we = (gnt_addr != '0);
`else
  assign gnt_we = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= CLEAR;
      clr_cnt   <= '0;
      ptr       <= '0;
      we3       <= 1'b0;
      wa3       <= '0;
      wd3       <= '0;
      init_done <= 1'b0;
      grant_idx <= '0;
    end else begin
      case (state)
        CLEAR: begin
          we3 <= 1'b1;
          wa3 <= clr_cnt[AW-1:0];
          wd3 <= '0;
          if (clr_cnt == CLR_LAST) begin
            state     <= ARB;
            init_done <= 1'b1;
            clr_cnt   <= '0;
          end else begin
            clr_cnt <= clr_cnt + (AW+1)'(1);
          end
        end
        ARB: begin
          if (clr_req) begin
            state     <= CLEAR;
            init_done <= 1'b0;
            clr_cnt   <= '0;
            we3       <= 1'b0;
          end else if (gnt_found) begin
            we3       <= gnt_we;
            wa3       <= gnt_addr;
            wd3       <= gnt_data;
            ptr       <= ptr_nxt;
            grant_idx <= gnt_idx;
          end else begin
            we3 <= 1'b0;
          end
        end
        default: state <= CLEAR;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: clear sweeps, round-robin table vectors, hold/clear/reset corners.
module tb_regfile_wb_arbiter;

  logic        clk;
  logic        rst;
  logic        wb_hold;
  logic        clr_req;
  logic        we3;
  logic [4:0]  wa3;
  logic [31:0] wd3;
  logic        init_done;
  logic [2:0]  grant_idx;

  int checks = 0;
  int errors = 0;
  logic [2:0] m_gidx = 3'd0;

  regfile_wb_arbiter_if #(.N_REQ(3), .DW(32), .AW(5)) bus ();

  regfile_wb_arbiter #(.N_REQ(3), .DW(32), .AW(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (bus),
    .wb_hold   (wb_hold),
    .clr_req   (clr_req),
    .we3       (we3),
    .wa3       (wa3),
    .wd3       (wd3),
    .init_done (init_done),
    .grant_idx (grant_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  valid;
    logic [14:0] addr;
    logic [95:0] data;
    logic        hold;
    logic [2:0]  exp_ready;
  } vec_t;

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } wr_t;

  vec_t tbl[$];
  wr_t  sb[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [2:0] v, input logic [14:0] a, input logic [95:0] d,
                              input logic h, input logic [2:0] r);
    vec_t x;
    x.valid = v; x.addr = a; x.data = d; x.hold = h; x.exp_ready = r;
    return x;
  endfunction

  // Entered before the edge that issues clr_cnt=0; leaves just after the edge that issues 31.
  task automatic sweep();
    for (int k = 0; k < 32; k++) begin
      clr_req = (k == 10);
      #1 chk("sweep_ready", 64'(bus.req_ready), 64'd0);
      @(posedge clk); #1;
      chk("sweep_we3", 64'(we3), 64'd1);
      chk("sweep_wa3", 64'(wa3), 64'(k));
      chk("sweep_wd3", 64'(wd3), 64'd0);
      chk("sweep_init_done", 64'(init_done), (k == 31) ? 64'd1 : 64'd0);
    end
    clr_req = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int   idx;
    logic exp_we;
    wr_t  w;
    bus.req_valid = v.valid;
    bus.req_addr  = v.addr;
    bus.req_data  = v.data;
    wb_hold       = v.hold;
    clr_req       = 1'b0;
    #1 chk("ready", 64'(bus.req_ready), 64'(v.exp_ready));
    exp_we = 1'b0;
    if (v.exp_ready != 3'b000) begin
      idx = 0;
      for (int i = 0; i < 3; i++) if (v.exp_ready[i]) idx = i;
      w.a = v.addr[idx*5 +: 5];
      w.d = v.data[idx*32 +: 32];
      m_gidx = 3'(idx);
      exp_we = 1'b1;
`ifdef REGFILE_ZERO_PROTECT_EN
      if (w.a == 5'd0) exp_we = 1'b0;
`endif
      if (exp_we) sb.push_back(w);
    end
    @(posedge clk); #1;
    chk("we3", 64'(we3), 64'(exp_we));
    if (we3 === 1'b1) begin
      if (sb.size() == 0) begin
        chk("sb_nonempty", 64'd0, 64'd1);
      end else begin
        w = sb.pop_front();
        chk("wa3", 64'(wa3), 64'(w.a));
        chk("wd3", 64'(wd3), 64'(w.d));
      end
    end
    chk("grant_idx", 64'(grant_idx), 64'(m_gidx));
  endtask

  localparam logic [31:0] D0 = 32'h1111_0000;
  localparam logic [31:0] D1 = 32'h2222_0001;
  localparam logic [31:0] D2 = 32'h3333_0002;

  initial begin
    rst = 1'b0; wb_hold = 1'b0; clr_req = 1'b0;
    bus.req_valid = '0; bus.req_addr = '0; bus.req_data = '0;

    tbl.push_back(mk(3'b010, {5'd0, 5'd5, 5'd0}, {32'd0, 32'hDEADBEEF, 32'd0}, 1'b0, 3'b010));
    tbl.push_back(mk(3'b000, '0, '0, 1'b0, 3'b000));
    tbl.push_back(mk(3'b100, {5'd9, 5'd0, 5'd0}, {32'h0000_0909, 64'd0}, 1'b0, 3'b100));
    for (int i = 0; i < 2; i++) begin
      tbl.push_back(mk(3'b111, {5'd3, 5'd2, 5'd1}, {D2, D1, D0}, 1'b0, 3'b001));
      tbl.push_back(mk(3'b111, {5'd3, 5'd2, 5'd1}, {D2, D1, D0}, 1'b0, 3'b010));
      tbl.push_back(mk(3'b111, {5'd3, 5'd2, 5'd1}, {D2, D1, D0}, 1'b0, 3'b100));
    end
    tbl.push_back(mk(3'b101, {5'd30, 5'd0, 5'd17}, {32'hCAFE_0030, 32'd0, 32'hBEEF_0017}, 1'b1, 3'b000));
    tbl.push_back(mk(3'b101, {5'd30, 5'd0, 5'd17}, {32'hCAFE_0030, 32'd0, 32'hBEEF_0017}, 1'b1, 3'b000));
    tbl.push_back(mk(3'b101, {5'd30, 5'd0, 5'd17}, {32'hCAFE_0030, 32'd0, 32'hBEEF_0017}, 1'b0, 3'b001));
    tbl.push_back(mk(3'b100, {5'd30, 5'd0, 5'd17}, {32'hCAFE_0030, 32'd0, 32'hBEEF_0017}, 1'b0, 3'b100));
    tbl.push_back(mk(3'b011, {5'd0, 5'd12, 5'd11}, {32'd0, 32'h0000_0012, 32'h0000_0011}, 1'b0, 3'b001));
    tbl.push_back(mk(3'b011, {5'd0, 5'd12, 5'd11}, {32'd0, 32'h0000_0012, 32'h0000_0011}, 1'b0, 3'b010));
    tbl.push_back(mk(3'b100, {5'd0, 5'd0, 5'd0}, {32'd7, 64'd0}, 1'b0, 3'b100));
    tbl.push_back(mk(3'b001, {10'd0, 5'd20}, {64'd0, 32'h0000_0020}, 1'b1, 3'b000));
    tbl.push_back(mk(3'b000, '0, '0, 1'b0, 3'b000));

    #2;
    chk("rst_we3", 64'(we3), 64'd0);
    chk("rst_wa3", 64'(wa3), 64'd0);
    chk("rst_wd3", 64'(wd3), 64'd0);
    chk("rst_grant_idx", 64'(grant_idx), 64'd0);
    chk("rst_init_done", 64'(init_done), 64'd0);
    chk("rst_ready", 64'(bus.req_ready), 64'd0);
    #10 rst = 1'b1;
    sweep();

    foreach (tbl[i]) run_vec(tbl[i]);

    // clr_req beats a valid requester, then that requester wins the first ARB cycle
    bus.req_valid = 3'b001; bus.req_addr = {10'd0, 5'd4}; bus.req_data = {64'd0, 32'h0000_ABCD};
    clr_req = 1'b1;
    #1 chk("clr_ready", 64'(bus.req_ready), 64'd0);
    @(posedge clk); #1;
    chk("clr_we3", 64'(we3), 64'd0);
    chk("clr_grant_idx", 64'(grant_idx), 64'(m_gidx));
    clr_req = 1'b0;
    sweep();
    run_vec(mk(3'b001, {10'd0, 5'd4}, {64'd0, 32'h0000_ABCD}, 1'b0, 3'b001));
    run_vec(mk(3'b111, {5'd3, 5'd2, 5'd1}, {D2, D1, D0}, 1'b0, 3'b010));

    // asynchronous reset mid-arbitration
    bus.req_valid = 3'b111;
    #3 rst = 1'b0;
    #1;
    chk("arst_we3", 64'(we3), 64'd0);
    chk("arst_wa3", 64'(wa3), 64'd0);
    chk("arst_wd3", 64'(wd3), 64'd0);
    chk("arst_grant_idx", 64'(grant_idx), 64'd0);
    chk("arst_init_done", 64'(init_done), 64'd0);
    chk("arst_ready", 64'(bus.req_ready), 64'd0);
    sb.delete();
    m_gidx = 3'd0;
    @(negedge clk);
    rst = 1'b1;
    sweep();
    run_vec(mk(3'b111, {5'd3, 5'd2, 5'd1}, {D2, D1, D0}, 1'b0, 3'b001));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
